// File: rtl/d_sram_resp_if.sv
// d_sram_resp_if
// Sram-like data port between the data cache (master) and the on-chip
// data RAM responder (slave).
//   data_sram_en    : request strobe, one request per cycle when high
//   data_sram_wen   : byte write enables, all zero means read
//   data_sram_addr  : byte address, bits [1:0] ignored by the responder
//   data_sram_wdata : write data
//   data_sram_rdata : read data returned by the responder
interface d_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/d_sram_resp.sv
// d_sram_resp
// Data-side SRAM responder: word-organised single-port RAM with byte write
// enables and a fixed read latency of READ_LATENCY cycles. Requests outside
// [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH) set a sticky error flag, leave the
// array untouched and return zero on reads.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : sram-like data port (slave side)
//   err_clr  : clears addr_err (a simultaneous new error wins)
//   addr_err : sticky out-of-range flag
//   rd_cnt   : accepted reads, 16-bit wrapping
//   wr_cnt   : accepted writes, 16-bit wrapping
module d_sram_resp #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    d_sram_resp_if.slave  bus,
    input  logic          err_clr,
    output logic          addr_err,
    output logic [15:0]   rd_cnt,
    output logic [15:0]   wr_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    // Byte span compared in 33 bits so a full 32-bit space cannot overflow.
    localparam logic [32:0] SPAN  = 33'd4 << ADDR_WIDTH;

    // Replace only the enabled byte lanes of a stored word.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]           mem_r [DEPTH];
    logic                  pipe_vld_r [READ_LATENCY];
    logic [31:0]           pipe_dat_r [READ_LATENCY];
    logic [31:0]           rdata_r;
    logic                  addr_err_r;
    logic [15:0]           rd_cnt_r;
    logic [15:0]           wr_cnt_r;

    logic [31:0]           off_s;
    logic                  in_range_s;
    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic                  rd_req_s;
    logic                  wr_req_s;
    logic                  wr_hit_s;
    logic                  bad_req_s;
    logic [31:0]           rd_word_s;

    // Unsigned offset wraps for addresses below BASE_ADDR, so they land out of range.
    assign off_s      = bus.data_sram_addr - BASE_ADDR;
    assign in_range_s = ({1'b0, off_s} < SPAN);
    assign word_idx_s = off_s[ADDR_WIDTH+1:2];
    assign rd_req_s   = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
    assign wr_req_s   = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
    assign wr_hit_s   = wr_req_s && in_range_s;
    assign bad_req_s  = bus.data_sram_en && !in_range_s;
    assign rd_word_s  = in_range_s ? mem_r[word_idx_s] : 32'h0000_0000;

    assign bus.data_sram_rdata = rdata_r;
    assign addr_err            = addr_err_r;
    assign rd_cnt              = rd_cnt_r;
    assign wr_cnt              = wr_cnt_r;

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_hit_s) begin
            mem_r[word_idx_s] <= merge_lanes(mem_r[word_idx_s], bus.data_sram_wdata,
                                             bus.data_sram_wen);
        end
    end

    // Read pipeline: array word is captured at the request edge, so a write on
    // the following edge cannot disturb it; rdata holds between valid returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_vld_r[k] <= 1'b0;
                pipe_dat_r[k] <= 32'h0000_0000;
            end
            rdata_r <= 32'h0000_0000;
        end else begin
            pipe_vld_r[0] <= rd_req_s;
            pipe_dat_r[0] <= rd_word_s;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld_r[k] <= pipe_vld_r[k-1];
                pipe_dat_r[k] <= pipe_dat_r[k-1];
            end
            if (pipe_vld_r[READ_LATENCY-1]) begin
                rdata_r <= pipe_dat_r[READ_LATENCY-1];
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Sticky error flag; a new error takes priority over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err_r <= 1'b0;
        end else if (bad_req_s) begin
            addr_err_r <= 1'b1;
        end else if (err_clr) begin
            addr_err_r <= 1'b0;
        end else begin
            addr_err_r <= addr_err_r;
        end
    end

    // Activity counters, counting in- and out-of-range requests alike.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_r <= 16'h0000;
            wr_cnt_r <= 16'h0000;
        end else begin
            if (rd_req_s) begin
                rd_cnt_r <= rd_cnt_r + 16'd1;
            end else begin
                rd_cnt_r <= rd_cnt_r;
            end
            if (wr_req_s) begin
                wr_cnt_r <= wr_cnt_r + 16'd1;
            end else begin
                wr_cnt_r <= wr_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_d_sram_resp.sv
// tb_d_sram_resp
// Self-checking bench for d_sram_resp. Two instances: u1 with the default
// configuration (latency 1, base 0, 16 KiB) driven from a vector table, and
// u3 (latency 3, base 0x1000_0000, 16 words) driven by hand-written sequences.
module tb_d_sram_resp;

    localparam logic [31:0] BASE3 = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr1, clr3;
    logic        err1, err3;
    logic [15:0] rd1, wr1, rd3, wr3;

    d_sram_resp_if bus1 ();
    d_sram_resp_if bus3 ();

    d_sram_resp #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1), .err_clr(clr1),
        .addr_err(err1), .rd_cnt(rd1), .wr_cnt(wr1)
    );

    d_sram_resp #(.ADDR_WIDTH(4), .BASE_ADDR(BASE3), .READ_LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .bus(bus3), .err_clr(clr3),
        .addr_err(err3), .rd_cnt(rd3), .wr_cnt(wr3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        clr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    logic [31:0] w3 [4];
    logic [31:0] w2_new;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic clr);
        bus1.data_sram_en    = en;
        bus1.data_sram_wen   = wen;
        bus1.data_sram_addr  = addr;
        bus1.data_sram_wdata = wdata;
        clr1                 = clr;
    endtask

    task automatic drive3(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic clr);
        bus3.data_sram_en    = en;
        bus3.data_sram_wen   = wen;
        bus3.data_sram_addr  = addr;
        bus3.data_sram_wdata = wdata;
        clr3                 = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            en    wen      addr           wdata          clr   rdata          err   rd      wr
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 32'h0000_0000, 1'b0, 16'd0, 16'd1};
        vecs[1]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 16'd0, 16'd2};
        vecs[2]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 16'd1, 16'd2};
        vecs[3]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 16'd1, 16'd2};
        vecs[4]  = '{1'b1, 4'hF, 32'h0000_0040, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF, 1'b0, 16'd1, 16'd3};
        vecs[5]  = '{1'b1, 4'h5, 32'h0000_0040, 32'hAABB_CCDD, 1'b0, 32'hDEAD_BEEF, 1'b0, 16'd1, 16'd4};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 16'd2, 16'd4};
        vecs[7]  = '{1'b1, 4'h0, 32'h0000_0043, 32'h0000_0000, 1'b0, 32'h11BB_33DD, 1'b0, 16'd3, 16'd4};
        vecs[8]  = '{1'b1, 4'hF, 32'h0000_4000, 32'h5555_5555, 1'b0, 32'h11BB_33DD, 1'b1, 16'd3, 16'd5};
        vecs[9]  = '{1'b1, 4'h0, 32'h0000_4000, 32'h0000_0000, 1'b0, 32'h11BB_33DD, 1'b1, 16'd4, 16'd5};
        vecs[10] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 16'd5, 16'd5};
        vecs[11] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0BAD_F00D, 1'b0, 16'd5, 16'd5};
        vecs[12] = '{1'b1, 4'h0, 32'h0000_4004, 32'h0000_0000, 1'b1, 32'h0BAD_F00D, 1'b1, 16'd6, 16'd5};
        vecs[13] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 16'd6, 16'd5};
        vecs[14] = '{1'b1, 4'hF, 32'h0000_3FFC, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000, 1'b0, 16'd6, 16'd6};
        vecs[15] = '{1'b1, 4'h0, 32'h0000_3FFC, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 16'd7, 16'd6};
        vecs[16] = '{1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 32'hA5A5_A5A5, 1'b0, 16'd7, 16'd7};
        vecs[17] = '{1'b1, 4'h0, 32'h0000_0200, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5, 1'b0, 16'd8, 16'd7};
        vecs[18] = '{1'b1, 4'h3, 32'h0000_0200, 32'h1234_5678, 1'b0, 32'hCAFE_F00D, 1'b0, 16'd8, 16'd8};
        vecs[19] = '{1'b1, 4'h0, 32'h0000_0200, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 1'b0, 16'd9, 16'd8};
        vecs[20] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hCAFE_5678, 1'b0, 16'd9, 16'd8};
        vecs[21] = '{1'b0, 4'hF, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0, 32'hCAFE_5678, 1'b0, 16'd9, 16'd8};

        w3[0]  = 32'h1111_1111;
        w3[1]  = 32'h2222_2222;
        w3[2]  = 32'h3333_3333;
        w3[3]  = 32'h4444_4444;
        w2_new = 32'h5A5A_0001;

        // Reset state
        rst = 1'b0;
        drive1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        drive3(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_rdata1", bus1.data_sram_rdata, 32'h0000_0000);
        chk("rst_err1", {31'd0, err1}, 32'd0);
        chk("rst_rd1", {16'd0, rd1}, 32'd0);
        chk("rst_wr1", {16'd0, wr1}, 32'd0);
        chk("rst_rdata3", bus3.data_sram_rdata, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors on u1
        for (int i = 0; i < NV; i++) begin
            drive1(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
            step();
            chk($sformatf("v%0d_rdata", i), bus1.data_sram_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), {31'd0, err1}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_rd", i), {16'd0, rd1}, {16'd0, vecs[i].exp_rd});
            chk($sformatf("v%0d_wr", i), {16'd0, wr1}, {16'd0, vecs[i].exp_wr});
        end
        drive1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        // u3: fill words 0..3
        for (int i = 0; i < 4; i++) begin
            drive3(1'b1, 4'hF, BASE3 + 32'(4 * i), w3[i], 1'b0);
            step();
        end
        chk("u3_fill_wr", {16'd0, wr3}, 32'd4);

        // u3: four back-to-back reads, data appears 3 edges after each
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive3(1'b1, 4'h0, BASE3 + 32'(4 * c), 32'h0, 1'b0);
            else       drive3(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
            step();
            chk($sformatf("lat3_c%0d", c), bus3.data_sram_rdata,
                (c < 3) ? 32'h0000_0000 : w3[c-3]);
        end
        chk("lat3_rd", {16'd0, rd3}, 32'd4);

        // u3: read, idle, write, read -> rdata holds across the gap
        drive3(1'b1, 4'h0, BASE3 + 32'h4, 32'h0, 1'b0);    step();
        chk("gap_c0", bus3.data_sram_rdata, w3[3]);
        drive3(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);             step();
        chk("gap_c1", bus3.data_sram_rdata, w3[3]);
        drive3(1'b1, 4'hF, BASE3 + 32'h8, w2_new, 1'b0);    step();
        chk("gap_c2", bus3.data_sram_rdata, w3[3]);
        drive3(1'b1, 4'h0, BASE3 + 32'h8, 32'h0, 1'b0);    step();
        chk("gap_c3", bus3.data_sram_rdata, w3[1]);
        drive3(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);             step();
        chk("gap_c4", bus3.data_sram_rdata, w3[1]);
        step();
        chk("gap_c5", bus3.data_sram_rdata, w3[1]);
        step();
        chk("gap_c6", bus3.data_sram_rdata, w2_new);
        chk("gap_rd", {16'd0, rd3}, 32'd6);
        chk("gap_wr", {16'd0, wr3}, 32'd5);

        // u3: out of range just below and just above the window
        drive3(1'b1, 4'h0, BASE3 - 32'h4, 32'h0, 1'b0);    step();
        chk("oor_below_err", {31'd0, err3}, 32'd1);
        drive3(1'b1, 4'h0, BASE3 + 32'h40, 32'h0, 1'b1);   step();
        chk("oor_above_clr_err", {31'd0, err3}, 32'd1);
        drive3(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);             step();
        chk("oor_clr_err", {31'd0, err3}, 32'd0);
        chk("oor_hold", bus3.data_sram_rdata, w2_new);
        drive3(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);             step();
        chk("oor_rdata0", bus3.data_sram_rdata, 32'h0000_0000);
        drive3(1'b1, 4'h0, BASE3 + 32'h8, 32'h0, 1'b0);    step();
        drive3(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        repeat (3) step();
        chk("reread_w2", bus3.data_sram_rdata, w2_new);

        // u1: read counter wrap (currently 9)
        drive1(1'b1, 4'h0, 32'h0000_0000, 32'h0, 1'b0);
        repeat (65526) step();
        chk("wrap_ffff", {16'd0, rd1}, 32'h0000_FFFF);
        step();
        chk("wrap_zero", {16'd0, rd1}, 32'h0000_0000);
        chk("wrap_wr_hold", {16'd0, wr1}, 32'd8);
        drive1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk("wrap_rdata", bus1.data_sram_rdata, 32'h0BAD_F00D);

        // u3: reset with two reads in flight
        drive3(1'b1, 4'h0, BASE3 + 32'h0, 32'h0, 1'b0);    step();
        drive3(1'b1, 4'h0, BASE3 + 32'hC, 32'h0, 1'b0);    step();
        chk("pre_rst_rd3", {16'd0, rd3}, 32'd11);
        drive3(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_rdata3", bus3.data_sram_rdata, 32'h0000_0000);
        chk("async_rst_err3", {31'd0, err3}, 32'd0);
        chk("async_rst_rd3", {16'd0, rd3}, 32'd0);
        chk("async_rst_wr3", {16'd0, wr3}, 32'd0);
        chk("async_rst_rdata1", bus1.data_sram_rdata, 32'h0000_0000);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("post_rst_c%0d", c), bus3.data_sram_rdata, 32'h0000_0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
